wormhole_output_arbiter: RTL
============================

// Module: wormhole_output_arbiter
// PURPOSE
//  Clocked wormhole arbiter for one router output port. Shares the port among INPORTS input-port
//  modules, whose route selectors raise a per-output request. Grants one input per packet
//  (round-robin), holds the grant until that input's tail flit passes, then releases.
//  Its grant vector drives the per-input packet-enable lines and the output data mux select.
// PARAMETERS
//  INPORTS     4    number of competing input ports (>=2)
//  HOLD_WIDTH  8    width of grant-hold cycle counter
//  TIMEOUT     200  watchdog limit in cycles (1..2**HOLD_WIDTH-1); used only with WATCHDOG_EN
// PORTS
//  clk           in   1                  clock, all state on rising edge
//  reset         in   1                  asynchronous, active-low reset
//  gen_enable    in   1                  1 = new grants allowed; 0 = no new grant, current one kept
//  req_i         in   INPORTS            level request per input (route selected this output)
//  tail_i        in   INPORTS            1-cycle pulse: tail flit of that input passed the port
//  grant_o       out  INPORTS            one-hot grant (all-zero when idle) = packet enable
//  grant_idx_o   out  $clog2(INPORTS)    index of granted input (valid while busy_o)
//  busy_o        out  1                  1 while a packet owns the port
//  hold_cnt_o    out  HOLD_WIDTH         cycles current grant has been held, saturating
//  timeout_o     out  1                  1-cycle pulse on watchdog release (tied 0 without macro)
// BEHAVIOUR
//  - Reset (reset=0, any time, async): state=IDLE, grant_o=0, grant_idx_o=0, busy_o=0,
//    hold_cnt_o=0, timeout_o=0, rr pointer=0. Mid-packet reset drops the grant immediately.
//  - FSM states IDLE, GRANT, RELEASE; all outputs registered.
//  - IDLE: if gen_enable && |req_i -> pick first requester at or after pointer (wrap mod INPORTS),
//    register grant; grant_o visible the cycle after req sampled (latency 1). Else stay.
//  - GRANT: grant_o constant; hold_cnt increments each cycle, saturates at 2**HOLD_WIDTH-1.
//    tail_i[grant_idx] sampled 1 -> RELEASE. tail_i of other inputs ignored.
//    req_i deassert of owner without tail: grant kept (wormhole, no preemption).
//    gen_enable=0 does not affect an active grant.
//  - RELEASE: exactly one cycle, grant_o=0, busy_o=0, hold_cnt cleared; pointer <=
//    (grant_idx+1) mod INPORTS (wraps INPORTS-1 -> 0); -> IDLE. Requests seen here are served
//    from IDLE next cycle (min 2 idle-to-grant cycles between packets).
//  - Tail pulse in the same cycle as grant assertion counts (owner's single-flit packet).
//  - Simultaneous requests: only rr order decides; a continuously requesting input is served
//    within INPORTS packets (no starvation).
// CONFIGURATION
//  WATCHDOG_EN defined: in GRANT, when hold_cnt reaches TIMEOUT-1 without owner tail, force
//    RELEASE and pulse timeout_o in that RELEASE cycle; pointer advances as normal. Tail and
//    timeout in the same cycle: treated as tail, timeout_o stays 0.
//  WATCHDOG_EN undefined: no forced release, timeout_o tied 0, hold_cnt_o still counts.
// STRUCTURE
//  Package wormhole_arb_pkg: typedef enum logic[1:0] arb_state_t {IDLE,GRANT,RELEASE};
//    function onehot(idx) and localparam default TIMEOUT.
//  Sub-module rr_pick #(INPORTS): combinational, inputs req vector + pointer, outputs found
//    and index of first requester at/after pointer. FSM, counter and registers in top.
// TESTING
//  1 reset then req_i=4'b0100 -> grant_o=4'b0100, grant_idx_o=2 one cycle later; busy_o=1.
//  2 owner 2, tail_i=4'b0001 then 4'b0100 -> first ignored; second gives grant_o=0 for one
//    cycle, next grant from input 3 if requested.
//  3 req_i=4'b1111 held, tail after each grant -> grant order 0,1,2,3,0 (wrap check).
//  4 gen_enable=0 with req_i=4'b0010 -> no grant; set gen_enable=0 during active grant ->
//    grant held until tail.
//  5 WATCHDOG_EN, TIMEOUT=10, no tail -> release after 10 grant cycles, timeout_o 1 pulse;
//    without macro grant persists, hold_cnt_o saturates at 255.
//  6 assert reset mid-packet -> grant_o=0 asynchronously; after release, req_i=4'b1000 ->
//    grant to input 3 (pointer back at 0).

Source files
------------

// File: rtl/wormhole_arb_pkg.sv
// rtl/wormhole_arb_pkg.sv - shared types, defaults and helpers for the wormhole output arbiter
package wormhole_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 200;
    localparam int MAX_PORTS       = 32;

    // One-hot vector with bit idx set; callers size-cast to their port count
    function automatic logic [MAX_PORTS-1:0] onehot(input int unsigned idx);
        logic [MAX_PORTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wormhole_output_arbiter_rr_pick.sv
// rtl/wormhole_output_arbiter_rr_pick.sv - first requester at or after the round-robin pointer
module rr_pick #(
    parameter int INPORTS = 4
) (
    input  logic [INPORTS-1:0]         i_req,
    input  logic [$clog2(INPORTS)-1:0] i_ptr,
    output logic                       o_found,
    output logic [$clog2(INPORTS)-1:0] o_idx
);

    localparam int IDXW = $clog2(INPORTS);

    // Scan from farthest offset down so the nearest requester at/after the pointer wins last
    always_comb begin
        int j;
        j       = 0;
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = INPORTS - 1; i >= 0; i--) begin
            j = int'(i_ptr) + i;
            if (j >= INPORTS) j = j - INPORTS;
            if (i_req[j]) begin
                o_found = 1'b1;
                o_idx   = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/wormhole_output_arbiter.sv
// rtl/wormhole_output_arbiter.sv - round-robin wormhole grant for one router output; WATCHDOG_EN adds forced release
module wormhole_output_arbiter
    import wormhole_arb_pkg::*;
#(
    parameter int INPORTS    = 4,
    parameter int HOLD_WIDTH = 8,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       gen_enable,
    input  logic [INPORTS-1:0]         req_i,
    input  logic [INPORTS-1:0]         tail_i,
    output logic [INPORTS-1:0]         grant_o,
    output logic [$clog2(INPORTS)-1:0] grant_idx_o,
    output logic                       busy_o,
    output logic [HOLD_WIDTH-1:0]      hold_cnt_o,
    output logic                       timeout_o
);

    localparam int IDXW = $clog2(INPORTS);

    arb_state_t            r_state;
    logic [INPORTS-1:0]    r_grant;
    logic [IDXW-1:0]       r_grant_idx;
    logic [IDXW-1:0]       r_ptr;
    logic                  r_busy;
    logic [HOLD_WIDTH-1:0] r_hold_cnt;
    logic                  r_timeout;

    logic                  w_found;
    logic [IDXW-1:0]       w_pick_idx;
    logic                  w_owner_tail;
    logic                  w_wd_fire;
    logic [IDXW-1:0]       w_ptr_next;

    rr_pick #(
        .INPORTS (INPORTS)
    ) u_rr_pick (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    assign w_owner_tail = tail_i[r_grant_idx];
    assign w_ptr_next   = (r_grant_idx == IDXW'(INPORTS - 1)) ? '0 : r_grant_idx + 1'b1;

`ifdef WATCHDOG_EN
    assign w_wd_fire = (r_hold_cnt == HOLD_WIDTH'(TIMEOUT - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT == 0);
    assign w_wd_fire            = 1'b0;
`endif

    // Arbiter FSM: grant per packet, hold until owner tail (or watchdog), one release cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
            r_busy      <= 1'b0;
            r_hold_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (gen_enable && w_found) begin
                        r_state     <= GRANT;
                        r_grant     <= INPORTS'(onehot(32'(w_pick_idx)));
                        r_grant_idx <= w_pick_idx;
                        r_busy      <= 1'b1;
                        r_hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (w_owner_tail || w_wd_fire) begin
                        // Tail wins over a coincident watchdog expiry
                        r_state    <= RELEASE;
                        r_grant    <= '0;
                        r_busy     <= 1'b0;
                        r_hold_cnt <= '0;
                        r_ptr      <= w_ptr_next;
                        r_timeout  <= !w_owner_tail;
                    end else if (r_hold_cnt != '1) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o     = r_grant;
    assign grant_idx_o = r_grant_idx;
    assign busy_o      = r_busy;
    assign hold_cnt_o  = r_hold_cnt;
    assign timeout_o   = r_timeout;

endmodule
